// File: rtl/weight_mem_loader.sv
// Packs a DATA_WIDTH byte stream into MEMORY_WIDTH words and writes them to consecutive addresses.
// Strobe appears one cycle after the last byte of each word; s_ready_o drops during the write cycle.
module weight_mem_loader #(
    parameter int MEMORY_WIDTH = 72,
    parameter int ADDRS_WIDTH  = 8,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDRS_WIDTH-1:0]  base_addrs_i,
    input  logic [ADDRS_WIDTH:0]    num_words_i,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [MEMORY_WIDTH-1:0] mem2_data_o,
    output logic [ADDRS_WIDTH-1:0]  wr_addrs_mem2_o,
    output logic                    wr_mem2_ld_o,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int K  = MEMORY_WIDTH / DATA_WIDTH;
    localparam int BW = (K > 1) ? $clog2(K) : 1;
    localparam logic [BW-1:0]        LAST_BYTE = BW'(K - 1);
    localparam logic [ADDRS_WIDTH:0] MAX_WORDS = {1'b1, {ADDRS_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           byte_cnt_q, byte_cnt_d;
    logic [ADDRS_WIDTH:0]    word_cnt_q, word_cnt_d;
    logic [ADDRS_WIDTH:0]    count_q, count_d;
    logic [ADDRS_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDRS_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [MEMORY_WIDTH-1:0] pack_q, pack_d;
    logic [MEMORY_WIDTH-1:0] data_q, data_d;
    logic                    ld_q, ld_d;

    logic                    xfer;
    logic                    last_xfer;
    logic [ADDRS_WIDTH:0]    eff_num;
    logic [ADDRS_WIDTH:0]    word_cnt_inc;
    logic [MEMORY_WIDTH-1:0] packed_w;

    assign xfer         = s_valid_i && (state_q == LOAD);
    assign last_xfer    = xfer && (byte_cnt_q == LAST_BYTE);
    // Any count with the top bit set exceeds the address space; clamp to one full sweep.
    assign eff_num      = num_words_i[ADDRS_WIDTH] ? MAX_WORDS : num_words_i;
    assign word_cnt_inc = word_cnt_q + {{ADDRS_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        packed_w = pack_q;
        for (int n = 0; n < K; n++) begin
            if (byte_cnt_q == BW'(n)) begin
                packed_w[n*DATA_WIDTH +: DATA_WIDTH] = s_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            pack_q     <= '0;
            data_q     <= '0;
            ld_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            pack_q     <= pack_d;
            data_q     <= data_d;
            ld_q       <= ld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (eff_num == '0) ? DONE : LOAD;
            LOAD:    if (last_xfer) state_d = WRITE;
            WRITE:   state_d = (word_cnt_inc == count_q) ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        count_d    = count_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        pack_d     = pack_q;
        data_d     = data_q;
        ld_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d     = base_addrs_i;
                    count_d    = eff_num;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    pack_d     = '0;
                end
            end
            LOAD: begin
                if (last_xfer) begin
                    data_d     = packed_w;
                    wr_addr_d  = addr_q;
                    ld_d       = 1'b1;
                    byte_cnt_d = '0;
                    pack_d     = '0;
                end else if (xfer) begin
                    pack_d     = packed_w;
                    byte_cnt_d = byte_cnt_q + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            WRITE: begin
                addr_d     = addr_q + {{(ADDRS_WIDTH-1){1'b0}}, 1'b1};
                word_cnt_d = word_cnt_inc;
            end
            default: ;
        endcase
    end

    always_comb begin
        s_ready_o       = (state_q == LOAD);
        busy_o          = (state_q != IDLE);
        done_o          = (state_q == DONE);
        mem2_data_o     = data_q;
        wr_addrs_mem2_o = wr_addr_q;
        wr_mem2_ld_o    = ld_q;
    end
endmodule
